div_sequencer: RTL
==================

# div_sequencer

Multi-cycle divide sequencer for the execute stage of the pipelined MIPS core. It accepts a DIV/DIVU issued by the decode/execute control path and runs a radix-2 restoring division, one quotient bit per cycle. While running, it holds the pipeline through a stall request. On completion it delivers quotient/remainder with a one-cycle HI/LO write strobe.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- startE  in  1  divide request; valid only together with the execute-stage divide flag.
- signedE  in  1  1 = DIV (signed), 0 = DIVU.
- cancelE  in  1  abort (exception/flush); overrides everything except reset.
- a_i  in  WIDTH  dividend.
- b_i  in  WIDTH  divisor.
- stall_o  out  1  pipeline hold request to the hazard unit.
- done_o  out  1  one-cycle completion pulse.
- hilo_we_o  out  1  HI/LO write enable; identical timing to done_o.
- lo_o  out  WIDTH  quotient.
- hi_o  out  WIDTH  remainder.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=0 at an edge): state=IDLE; stall_o, done_o, hilo_we_o = 0; lo_o, hi_o = 0; counter and internal registers = 0.
- IDLE:
  - startE=1 and b_i≠0: capture |a_i|, |b_i| (raw values when signedE=0); latch quotient sign = sign(a)^sign(b) and remainder sign = sign(a) (signed only); clear partial remainder; counter=0; go to BUSY.
  - startE=1 and b_i=0: load lo=all-ones, hi=a_i; go to DONE.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor from rem, using WIDTH+1-bit arithmetic so no carry is lost.
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - Increment the counter. After iteration WIDTH (counter = WIDTH-1), go to DONE.
- DONE:
  - Apply sign fix-up (two's-complement negate of quotient and/or remainder per the latched signs) into lo_o/hi_o.
  - Assert done_o and hilo_we_o for this cycle only, then go to IDLE.
  - -2^31 / -1 wraps naturally: lo=0x80000000, hi=0.
- lo_o/hi_o are registered; they change only on entering DONE and otherwise hold the last result.
- startE in BUSY or DONE is ignored. A new divide is accepted only in IDLE.
- cancelE=1 in any state: next state IDLE, no done_o/hilo_we_o, lo_o/hi_o unchanged. If cancelE and startE are both high in IDLE, cancel wins and nothing starts.

## Timing
- Cycle 0 = edge where startE is sampled in IDLE.
- stall_o is combinational: (IDLE & startE & ~cancelE) | BUSY. It is high in cycle 0 and throughout BUSY, and low in DONE so the instruction advances as results are written.
- Normal latency: BUSY covers cycles 1..WIDTH; DONE is cycle WIDTH+1 (33). stall_o is high for 33 cycles total.
- Divide by zero: DONE in cycle 1; stall_o is high in cycle 0 only.
- Back-to-back divides: the earliest next accept is the cycle after DONE.
- Reset mid-operation: rst=0 at any edge returns to the reset state at that edge, regardless of other inputs.

## Structure
- Shared package: state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), the DIV_CYCLES=WIDTH constant, and the counter width $clog2(WIDTH).
- One sub-module: div_step, a combinational single iteration. Inputs: rem, quo, divisor. Outputs: next rem, next quo. It keeps the FSM file free of datapath arithmetic.
- Sign handling (abs at entry, negate at exit) stays in div_sequencer.

## Test plan
- Unsigned: startE, signedE=0, a=100, b=7 → stall_o high cycles 0..32; cycle 33: done_o=hilo_we_o=1, lo=14, hi=2; stall_o=0.
- Signed: a=0xFFFFFFF9 (-7), b=2 → cycle 33: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- Overflow: signed a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Unsigned same operands → lo=0, hi=0x80000000.
- Divide by zero: a=5, b=0 → cycle 1: done_o=1, lo=0xFFFFFFFF, hi=5; stall_o high only in cycle 0.
- Cancel: prior result lo=14/hi=2; start a=1000, b=3; cancelE=1 at cycle 10 → IDLE at cycle 11, no done_o, lo/hi still 14/2. Restart at cycle 12 → done at cycle 45, lo=333, hi=1. startE held high during BUSY has no effect.
- Reset: rst=0 at cycle 20 of a divide → next cycle all outputs 0, state IDLE. The first start after reset completes normally.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: operand width,
// iteration count, counter width, FSM state encoding and a negate helper.
package div_sequencer_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;
  localparam int DIV_CNT_W  = $clog2(DIV_WIDTH);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Two's-complement negate when doNeg is set; used for abs() and sign fix-up.
  function automatic logic [DIV_WIDTH-1:0] negIf(input logic doNeg,
                                                 input logic [DIV_WIDTH-1:0] value);
    return doNeg ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring division iteration. The {rem, quo} pair is shifted
// left by one, the divisor is trial-subtracted from the widened remainder,
// and the quotient LSB records whether the subtraction was kept.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic [WIDTH-1:0] nextQuo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           negative;

  // The remainder is always below the divisor, so a WIDTH+1-bit difference
  // holds every trial result and its top bit is a reliable borrow flag.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    negative = diff[WIDTH];
    nextRem  = negative ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    nextQuo  = {quo[WIDTH-2:0], ~negative};
  end

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage DIV/DIVU sequencer: runs one restoring-division iteration per
// cycle, holds the pipeline while busy and writes HI/LO with a one-cycle
// strobe when the result is ready.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic             cancelE,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             done_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam logic [DIV_CNT_W-1:0] LastCount = DIV_CNT_W'(DIV_CYCLES - 1);

  logic [1:0]           state;
  logic [DIV_CNT_W-1:0] count;
  logic [WIDTH-1:0]     remReg;
  logic [WIDTH-1:0]     quoReg;
  logic [WIDTH-1:0]     divisorReg;
  logic                 negQuo;
  logic                 negRem;

  logic [WIDTH-1:0]     stepRem;
  logic [WIDTH-1:0]     stepQuo;
  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (remReg),
    .quo     (quoReg),
    .divisor (divisorReg),
    .nextRem (stepRem),
    .nextQuo (stepQuo)
  );

  // Operand magnitudes; DIVU passes the raw bit patterns straight through.
  always_comb begin
    absA = negIf(signedE & a_i[WIDTH-1], a_i);
    absB = negIf(signedE & b_i[WIDTH-1], b_i);
  end

  // Pipeline hold and completion strobes; a cancel suppresses a pending write.
  always_comb begin
    stall_o   = ((state == IDLE) & startE & ~cancelE) | (state == BUSY);
    done_o    = (state == DONE) & ~cancelE;
    hilo_we_o = (state == DONE) & ~cancelE;
  end

  // Sequencer FSM and datapath registers; results load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      lo_o       <= '0;
      hi_o       <= '0;
    end else if (cancelE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (startE) begin
            if (b_i != '0) begin
              divisorReg <= absB;
              quoReg     <= absA;
              remReg     <= '0;
              count      <= '0;
              negQuo     <= signedE & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              negRem     <= signedE & a_i[WIDTH-1];
              state      <= BUSY;
            end else begin
              lo_o  <= '1;
              hi_o  <= a_i;
              state <= DONE;
            end
          end
        end
        BUSY: begin
          remReg <= stepRem;
          quoReg <= stepQuo;
          count  <= count + 1'b1;
          if (count == LastCount) begin
            lo_o  <= negIf(negQuo, stepQuo);
            hi_o  <= negIf(negRem, stepRem);
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
